// File: rtl/arb_pkg.sv
// arb_pkg: state encoding and helpers shared by the round-robin arbiter.
// FSM states are one-hot so the state output can be used directly as a decode.
package arb_pkg;
    localparam int NUM_REQ_MAX = 8;
    typedef enum logic [2:0] {
        ST_IDLE = 3'b100,
        ST_OWN  = 3'b010,
        ST_GAP  = 3'b001
    } arb_state_t;
    function automatic logic [NUM_REQ_MAX-1:0] onehot(input logic [2:0] idx);
        onehot = NUM_REQ_MAX'(1) << idx;
    endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotating-priority picker.
// Searches from i_last+1 upward with wrap-around; the first set request wins.
module rr_pick
    import arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [2:0]         i_last,
    output logic [2:0]         o_winner,
    output logic               o_any_req
);
    logic [NUM_REQ_MAX-1:0] w_req;
    logic [3:0]             w_sum;
    logic [2:0]             w_idx;
    assign w_req     = NUM_REQ_MAX'(i_req);
    assign o_any_req = |i_req;
    // Walk the offsets from farthest to nearest so the nearest hit is kept.
    always_comb begin
        o_winner = '0;
        w_sum    = '0;
        w_idx    = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            w_sum = 4'(i_last) + 4'(i);
            w_idx = 3'(w_sum >= 4'(NUM_REQ) ? w_sum - 4'(NUM_REQ) : w_sum);
            if (w_req[w_idx]) o_winner = w_idx;
        end
    end
endmodule

// File: rtl/rr_arb_fsm.sv
// rr_arb_fsm: round-robin owner FSM for one shared resource with req/done
// handshake, a one-cycle turnaround gap and a hold-time limit.
module rr_arb_fsm
    import arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic               clk,
    input  logic               rst_b,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] done,
    output logic [NUM_REQ-1:0] grant,
    output logic [2:0]         grant_id,
    output logic               busy,
    output logic               timeout,
    output logic [2:0]         state
);
    arb_state_t             r_state, w_state_nx;
    logic [NUM_REQ-1:0]     r_grant, w_grant_nx;
    logic [2:0]             r_id, w_id_nx;
    logic [2:0]             r_last, w_last_nx;
    logic [2:0]             w_winner;
    logic [CNT_W-1:0]       r_cnt, w_cnt_nx;
    logic                   r_timeout, w_timeout_nx;
    logic                   w_any, w_own_done, w_own_req, w_limit;
    logic [NUM_REQ_MAX-1:0] w_done8, w_req8;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .i_req     (req),
        .i_last    (r_last),
        .o_winner  (w_winner),
        .o_any_req (w_any)
    );

    assign w_done8    = NUM_REQ_MAX'(done);
    assign w_req8     = NUM_REQ_MAX'(req);
    assign w_own_done = w_done8[r_id];
    assign w_own_req  = w_req8[r_id];
    assign w_limit    = r_cnt == CNT_W'(MAX_HOLD - 1);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_id      <= '0;
            r_last    <= 3'(NUM_REQ - 1);
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_grant   <= w_grant_nx;
            r_id      <= w_id_nx;
            r_last    <= w_last_nx;
            r_cnt     <= w_cnt_nx;
            r_timeout <= w_timeout_nx;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_grant_nx   = r_grant;
        w_id_nx      = r_id;
        w_last_nx    = r_last;
        w_cnt_nx     = r_cnt;
        w_timeout_nx = 1'b0;
        case (r_state)
            ST_IDLE, ST_GAP: begin
                w_cnt_nx   = '0;
                w_grant_nx = '0;
                w_state_nx = ST_IDLE;
                if (w_any) begin
                    w_state_nx = ST_OWN;
                    w_grant_nx = NUM_REQ'(onehot(w_winner));
                    w_id_nx    = w_winner;
                    w_last_nx  = w_winner;
                end
            end
            ST_OWN: begin
                w_cnt_nx = r_cnt + 1'b1;
                // done beats abandonment beats the limit; only the limit pulses timeout
                if (w_own_done || !w_own_req || w_limit) begin
                    w_state_nx   = ST_GAP;
                    w_grant_nx   = '0;
                    w_timeout_nx = w_own_req && !w_own_done;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_grant_nx = '0;
            end
        endcase
    end

    assign grant    = r_grant;
    assign grant_id = r_id;
    assign busy     = r_state == ST_OWN;
    assign timeout  = r_timeout;
    assign state    = r_state;
endmodule

// File: tb/tb_rr_arb_fsm.sv
// tb_rr_arb_fsm: directed scenarios plus random req/done traffic, checked
// against an ownership-level model of the arbiter rules.
module tb_rr_arb_fsm;
    localparam int N  = 4;
    localparam int MH = 8;

    logic         clk = 1'b0;
    logic         rst_b = 1'b0;
    logic [N-1:0] req = '0;
    logic [N-1:0] done = '0;
    logic [N-1:0] grant;
    logic [2:0]   grant_id;
    logic [2:0]   state;
    logic         busy;
    logic         timeout;

    int n_cmp = 0;
    int n_bad = 0;
    int m_owner = -1;
    int m_last = N - 1;
    int m_held = 0;
    bit m_gap = 1'b0;
    bit m_to = 1'b0;

    always #5 clk = ~clk;

    rr_arb_fsm #(.NUM_REQ(N), .MAX_HOLD(MH), .CNT_W(4)) dut (
        .clk      (clk),
        .rst_b    (rst_b),
        .req      (req),
        .done     (done),
        .grant    (grant),
        .grant_id (grant_id),
        .busy     (busy),
        .timeout  (timeout),
        .state    (state)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset;
        m_owner = -1;
        m_last  = N - 1;
        m_held  = 0;
        m_gap   = 1'b0;
        m_to    = 1'b0;
    endtask

    task automatic model_edge(input logic [N-1:0] r, input logic [N-1:0] d);
        bit found;
        m_to = 1'b0;
        if (m_owner >= 0) begin
            m_held++;
            if (d[m_owner] || !r[m_owner] || m_held == MH) begin
                m_to    = !d[m_owner] && r[m_owner];
                m_owner = -1;
                m_gap   = 1'b1;
            end
        end else begin
            m_gap = 1'b0;
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                int idx;
                idx = (m_last + k) % N;
                if (!found && r[idx]) begin
                    found   = 1'b1;
                    m_owner = idx;
                    m_last  = idx;
                    m_held  = 0;
                end
            end
        end
    endtask

    task automatic check_all;
        chk("grant", 32'(grant), m_owner >= 0 ? (32'd1 << m_owner) : 32'd0);
        chk("state", 32'(state), m_owner >= 0 ? 32'h2 : (m_gap ? 32'h1 : 32'h4));
        chk("busy", 32'(busy), 32'(m_owner >= 0));
        chk("timeout", 32'(timeout), 32'(m_to));
        chk("onehot", 32'($countones(grant) <= 1), 32'd1);
        if (m_owner >= 0) chk("grant_id", 32'(grant_id), 32'(m_owner));
    endtask

    task automatic step(input logic [N-1:0] r, input logic [N-1:0] d);
        req  = r;
        done = d;
        @(posedge clk);
        model_edge(r, d);
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset;
        rst_b = 1'b0;
        req   = '0;
        done  = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all();
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        rst_b = 1'b1;
    endtask

    initial begin
        logic [N-1:0] rq;
        do_reset();
        step('0, '0);
        step(4'b0101, '0);
        chk("p1_grant", 32'(grant), 32'h1);
        chk("p1_state", 32'(state), 32'h2);
        step(4'b0101, 4'b0001);
        chk("p1_gap_grant", 32'(grant), 32'h0);
        chk("p1_gap_state", 32'(state), 32'h1);
        step(4'b0101, '0);
        chk("p1_next", 32'(grant), 32'h4);

        do_reset();
        step(4'b1111, '0);
        for (int r = 0; r < 8; r++) begin
            chk("rot_grant", 32'(grant), 32'd1 << (r % 4));
            step(4'b1111, '0);
            step(4'b1111, '0);
            step(4'b1111, N'(1 << (r % 4)));
            chk("rot_gap", 32'(state), 32'h1);
            step(4'b1111, '0);
        end

        do_reset();
        step(4'b0100, '0);
        for (int i = 0; i < MH; i++) begin
            chk("to_hold", 32'(grant), 32'h4);
            step(4'b0100, '0);
        end
        chk("to_pulse", 32'(timeout), 32'd1);
        chk("to_gap", 32'(state), 32'h1);
        step(4'b0100, '0);
        chk("to_regrant", 32'(grant), 32'h4);
        chk("to_clear", 32'(timeout), 32'd0);
        for (int i = 0; i < MH; i++) step(4'b0100, i == MH - 1 ? 4'b0100 : 4'b0000);
        chk("lim_done_to", 32'(timeout), 32'd0);
        chk("lim_done_gap", 32'(state), 32'h1);

        do_reset();
        step(4'b0010, '0);
        chk("ab_grant", 32'(grant), 32'h2);
        step(4'b0010, '0);
        step(4'b1001, 4'b1000);
        chk("ab_release", 32'(grant), 32'h0);
        chk("ab_no_to", 32'(timeout), 32'd0);
        step(4'b1001, '0);
        chk("ab_next", 32'(grant), 32'h8);

        do_reset();
        step(4'b1000, '0);
        chk("ar_pre", 32'(grant), 32'h8);
        #2 rst_b = 1'b0;
        model_reset();
        #1;
        chk("ar_grant", 32'(grant), 32'h0);
        chk("ar_state", 32'(state), 32'h4);
        @(negedge clk);
        rst_b = 1'b1;
        step(4'b1000, '0);
        chk("ar_regrant", 32'(grant), 32'h8);
        chk("ar_id", 32'(grant_id), 32'd3);

        do_reset();
        rq = '0;
        for (int c = 0; c < 800; c++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(5) == 0) rq[b] = ~rq[b];
            step(rq, N'($urandom) & N'($urandom) & N'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
